// File: rtl/sprite_engine.sv
// sprite_engine: erase / move / redraw engine for one rectangular sprite on the
// VGA plot bus. On a tick it erases the sprite, steps it by dir and redraws it.
// Optional build macro: SPRITE_WRAP_EN. When it is defined, positions wrap
// around the screen edges and off-screen pixels are masked. When it is not
// defined, positions are clamped to the screen.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   tick               frame request (rising edge, honoured only in IDLE)
//   load               reload position from start_x/start_y (IDLE only)
//   start_x, start_y   initial/reload position
//   dir                [0]=right [1]=up [2]=down [3]=left
//   mode               fill mode: 0 solid, 1 col stripes, 2 checker, 3 row stripes
//   c_in, c2_in        primary / secondary draw colour
//   x_out, y_out, c_out, plot   registered pixel write to the VGA adapter
//   busy               high while a frame is in progress (registered)
//   frame_done         one-cycle pulse at the end of each frame
module sprite_engine #(
    parameter int unsigned SPR_W = 4,
    parameter int unsigned SPR_H = 4,
    parameter int unsigned X_W = 8,
    parameter int unsigned Y_W = 7,
    parameter int unsigned C_W = 3,
    parameter int unsigned X_MAX = 159,
    parameter int unsigned Y_MAX = 119,
    parameter int unsigned STEP = 1,
    parameter logic [C_W-1:0] BG_COLOR = C_W'(3'b111)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           load,
    input  logic [X_W-1:0] start_x,
    input  logic [Y_W-1:0] start_y,
    input  logic [3:0]     dir,
    input  logic [1:0]     mode,
    input  logic [C_W-1:0] c_in,
    input  logic [C_W-1:0] c2_in,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [C_W-1:0] c_out,
    output logic           plot,
    output logic           busy,
    output logic           frame_done
);

    typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, DONE} state_t;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned XS_W  = X_W + 1;
    localparam int unsigned YS_W  = Y_W + 1;
    localparam logic signed [XS_W-1:0] STEP_X = XS_W'(STEP);
    localparam logic signed [YS_W-1:0] STEP_Y = YS_W'(STEP);
`ifdef SPRITE_WRAP_EN
    localparam logic signed [XS_W-1:0] X_MOD = XS_W'(X_MAX + 1);
    localparam logic signed [YS_W-1:0] Y_MOD = YS_W'(Y_MAX + 1);
    localparam logic signed [XS_W-1:0] X_TOP = XS_W'(X_MAX);
    localparam logic signed [YS_W-1:0] Y_TOP = YS_W'(Y_MAX);
`else
    localparam logic signed [XS_W-1:0] X_LIM = XS_W'(X_MAX - SPR_W + 1);
    localparam logic signed [YS_W-1:0] Y_LIM = YS_W'(Y_MAX - SPR_H + 1);
`endif

    state_t             state, state_d;
    logic [CNT_W-1:0]   col, col_d, row, row_d;
    logic [X_W-1:0]     pos_x, pos_x_d, x_d;
    logic [Y_W-1:0]     pos_y, pos_y_d, y_d;
    logic [C_W-1:0]     c_d;
    logic               plot_d, busy_d, done_d, tick_q;
    logic signed [XS_W-1:0] dx, nx;
    logic signed [YS_W-1:0] dy, ny;
    logic               sel;
`ifdef SPRITE_WRAP_EN
    logic [XS_W-1:0]    px_sum;
    logic [YS_W-1:0]    py_sum;
`endif

    // State, counters, position and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            pos_x      <= start_x;
            pos_y      <= start_y;
            tick_q     <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            c_out      <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            col        <= col_d;
            row        <= row_d;
            pos_x      <= pos_x_d;
            pos_y      <= pos_y_d;
            tick_q     <= tick;
            x_out      <= x_d;
            y_out      <= y_d;
            c_out      <= c_d;
            plot       <= plot_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

    // Next state, scan counters, move arithmetic and next output values
    always_comb begin
        state_d = state;
        col_d   = col;
        row_d   = row;
        pos_x_d = pos_x;
        pos_y_d = pos_y;
        x_d     = x_out;
        y_d     = y_out;
        c_d     = c_out;
        plot_d  = 1'b0;
        busy_d  = (state != IDLE);
        done_d  = 1'b0;

        // Opposite directions on one axis cancel out
        dx = '0;
        if (dir[0] && !dir[3])      dx = STEP_X;
        else if (dir[3] && !dir[0]) dx = -STEP_X;
        dy = '0;
        if (dir[2] && !dir[1])      dy = STEP_Y;
        else if (dir[1] && !dir[2]) dy = -STEP_Y;
        nx = $signed({1'b0, pos_x}) + dx;
        ny = $signed({1'b0, pos_y}) + dy;

        unique case (mode)
            2'd0:    sel = 1'b0;
            2'd1:    sel = col[0];
            2'd2:    sel = col[0] ^ row[0];
            default: sel = row[0];
        endcase

`ifdef SPRITE_WRAP_EN
        px_sum = {1'b0, pos_x} + XS_W'(col);
        py_sum = {1'b0, pos_y} + YS_W'(row);
`endif

        unique case (state)
            IDLE: begin
                // load wins over tick; a held tick starts only one frame
                if (load) begin
                    pos_x_d = start_x;
                    pos_y_d = start_y;
                end else if (tick && !tick_q) begin
                    state_d = ERASE;
                end
            end
            ERASE, DRAW: begin
                plot_d = 1'b1;
`ifdef SPRITE_WRAP_EN
                x_d    = px_sum[X_W-1:0];
                y_d    = py_sum[Y_W-1:0];
                plot_d = (px_sum <= XS_W'(X_MAX)) && (py_sum <= YS_W'(Y_MAX));
`else
                x_d    = pos_x + X_W'(col);
                y_d    = pos_y + Y_W'(row);
`endif
                if (state == ERASE) c_d = BG_COLOR;
                else                c_d = sel ? c2_in : c_in;
                if (col == CNT_W'(SPR_W - 1)) begin
                    col_d = '0;
                    if (row == CNT_W'(SPR_H - 1)) begin
                        row_d   = '0;
                        state_d = (state == ERASE) ? MOVE : DONE;
                    end else begin
                        row_d = row + 1'b1;
                    end
                end else begin
                    col_d = col + 1'b1;
                end
            end
            MOVE: begin
`ifdef SPRITE_WRAP_EN
                if (nx[XS_W-1])     pos_x_d = X_W'(nx + X_MOD);
                else if (nx > X_TOP) pos_x_d = X_W'(nx - X_MOD);
                else                pos_x_d = nx[X_W-1:0];
                if (ny[YS_W-1])     pos_y_d = Y_W'(ny + Y_MOD);
                else if (ny > Y_TOP) pos_y_d = Y_W'(ny - Y_MOD);
                else                pos_y_d = ny[Y_W-1:0];
`else
                if (nx[XS_W-1])     pos_x_d = '0;
                else if (nx > X_LIM) pos_x_d = X_LIM[X_W-1:0];
                else                pos_x_d = nx[X_W-1:0];
                if (ny[YS_W-1])     pos_y_d = '0;
                else if (ny > Y_LIM) pos_y_d = Y_LIM[Y_W-1:0];
                else                pos_y_d = ny[Y_W-1:0];
`endif
                state_d = DRAW;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
